// File: rtl/pila_retorno.sv
// Return-address stack (LIFO) beside the program counter; dout is the top entry for the PC mux.
// Latency: a push at edge N is visible on dout after edge N; dout is combinational from registered state.
// No backpressure: push on full / pop on empty are dropped and flagged; optional macro PILA_ERR_STICKY_EN makes flags sticky.
module pila_retorno #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [PTR_W:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_MAX = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    // Occupancy class, decoded from count only; there is no separate state register.
    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_PARTIAL,
        ST_FULL
    } state_e;

    state_e             state;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]   sp_q, sp_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               ovf_q, unf_q;
    logic               ovf_evt, unf_evt;
    logic               wr_en;
    logic [PTR_W-1:0]   wr_addr;
    logic [PTR_W-1:0]   top_addr;

    // sp wraps to 0 when full, so sp-1 still addresses the top entry.
    assign top_addr = sp_q - PTR_ONE;

    // Classify occupancy from the registered count.
    always_comb begin
        state = ST_PARTIAL;
        if (count_q == '0) begin
            state = ST_EMPTY;
        end else if (count_q == CNT_MAX) begin
            state = ST_FULL;
        end
    end

    // Next pointer/count, memory write request and error events for this cycle.
    always_comb begin
        sp_d    = sp_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_addr = sp_q;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        unique case (state)
            ST_EMPTY: begin
                // Push+pop on an empty stack behaves as a plain push.
                if (push) begin
                    wr_en   = 1'b1;
                    sp_d    = sp_q + PTR_ONE;
                    count_d = count_q + CNT_ONE;
                end else if (pop) begin
                    unf_evt = 1'b1;
                end
            end
            ST_PARTIAL: begin
                if (push && pop) begin
                    wr_en   = 1'b1;
                    wr_addr = top_addr;
                end else if (push) begin
                    wr_en   = 1'b1;
                    sp_d    = sp_q + PTR_ONE;
                    count_d = count_q + CNT_ONE;
                end else if (pop) begin
                    sp_d    = top_addr;
                    count_d = count_q - CNT_ONE;
                end
            end
            ST_FULL: begin
                if (push && pop) begin
                    wr_en   = 1'b1;
                    wr_addr = top_addr;
                end else if (push) begin
                    ovf_evt = 1'b1;
                end else if (pop) begin
                    sp_d    = top_addr;
                    count_d = count_q - CNT_ONE;
                end
            end
            default: begin
                sp_d    = sp_q;
                count_d = count_q;
            end
        endcase
    end

    // Pointer, count and error-flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            count_q <= count_d;
`ifdef PILA_ERR_STICKY_EN
            ovf_q   <= ovf_q | ovf_evt;
            unf_q   <= unf_q | unf_evt;
`else
            ovf_q   <= ovf_evt;
            unf_q   <= unf_evt;
`endif
        end
    end

    // Entry storage; contents are don't-care after reset since count gates every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= din;
        end
    end

    assign dout      = (state == ST_EMPTY) ? '0 : mem_q[top_addr];
    assign empty     = (state == ST_EMPTY);
    assign full      = (state == ST_FULL);
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_pila_retorno.sv
module tb_pila_retorno;

    logic       clk = 1'b0;
    logic       reset;
    logic       push;
    logic       pop;
    logic [9:0] din;
    logic [9:0] dout;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    int total = 0;
    int bad   = 0;

    // Scoreboard: values expected to come back out of the stack, top at the back.
    logic [9:0] sb[$];

`ifdef PILA_ERR_STICKY_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    pila_retorno #(.WIDTH(10), .DEPTH(8)) dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din),
        .dout(dout), .empty(empty), .full(full), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // One clock of stimulus: inputs applied at negedge, outputs settle 1ns after posedge.
    task automatic drive(input logic p, input logic q, input logic [9:0] d);
        @(negedge clk);
        push = p; pop = q; din = d;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        #3 reset = 1'b1;
        #1;
        total++; if (count !== 4'd0)   begin bad++; $display("FAIL reset0_count got=%0d exp=0", count); end
        total++; if (empty !== 1'b1)   begin bad++; $display("FAIL reset0_empty got=%b exp=1", empty); end
        total++; if (full !== 1'b0)    begin bad++; $display("FAIL reset0_full got=%b exp=0", full); end
        total++; if (dout !== 10'h000) begin bad++; $display("FAIL reset0_dout got=%h exp=000", dout); end
        total++; if (overflow !== 1'b0 || underflow !== 1'b0)
            begin bad++; $display("FAIL reset0_err got=%b%b exp=00", overflow, underflow); end
        @(negedge clk); reset = 1'b0;
        drive(1'b1, 1'b0, 10'h155);
        drive(1'b1, 1'b0, 10'h2AB);
        total++; if (count !== 4'd2) begin bad++; $display("FAIL prereset_count got=%0d exp=2", count); end
        // Assert reset between edges: state must clear without a clock.
        @(negedge clk); #2 reset = 1'b1; #1;
        total++; if (count !== 4'd0)   begin bad++; $display("FAIL midreset_count got=%0d exp=0", count); end
        total++; if (dout !== 10'h000) begin bad++; $display("FAIL midreset_dout got=%h exp=000", dout); end
        total++; if (empty !== 1'b1)   begin bad++; $display("FAIL midreset_empty got=%b exp=1", empty); end
        @(negedge clk); reset = 1'b0;
        sb.delete();
    endtask

    task automatic test_lifo();
        logic [9:0] vals [3];
        logic [9:0] exp;
        vals[0] = 10'h005; vals[1] = 10'h0A1; vals[2] = 10'h3FF;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            sb.push_back(vals[i]);
            drive(1'b1, 1'b0, vals[i]);
        end
        total++; if (dout !== 10'h3FF) begin bad++; $display("FAIL lifo_top got=%h exp=3ff", dout); end
        total++; if (count !== 4'd3)   begin bad++; $display("FAIL lifo_count got=%0d exp=3", count); end
        for (int i = 0; i < 3; i++) begin
            exp = sb.pop_back();
            total++; if (dout !== exp) begin bad++; $display("FAIL lifo_pop%0d got=%h exp=%h", i, dout, exp); end
            drive(1'b0, 1'b1, 10'h000);
        end
        total++; if (empty !== 1'b1 || dout !== 10'h000)
            begin bad++; $display("FAIL lifo_drained got empty=%b dout=%h exp empty=1 dout=000", empty, dout); end
    endtask

    task automatic test_full_overflow();
        logic [9:0] exp;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            sb.push_back(10'h010 + 10'(i));
            drive(1'b1, 1'b0, 10'h010 + 10'(i));
        end
        total++; if (full !== 1'b1)    begin bad++; $display("FAIL full_flag got=%b exp=1", full); end
        total++; if (count !== 4'd8)   begin bad++; $display("FAIL full_count got=%0d exp=8", count); end
        total++; if (dout !== 10'h017) begin bad++; $display("FAIL full_top got=%h exp=017", dout); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_noovf got=%b exp=0", overflow); end
        drive(1'b1, 1'b0, 10'h1FF);
        total++; if (dout !== 10'h017 || count !== 4'd8)
            begin bad++; $display("FAIL ovf_hold got dout=%h count=%0d exp dout=017 count=8", dout, count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        drive(1'b0, 1'b0, 10'h000);
        total++; if (overflow !== STICKY) begin bad++; $display("FAIL ovf_after got=%b exp=%b", overflow, STICKY); end
        total++; if (underflow !== 1'b0)  begin bad++; $display("FAIL ovf_nounf got=%b exp=0", underflow); end
        for (int i = 0; i < 8; i++) begin
            exp = sb.pop_back();
            total++; if (dout !== exp) begin bad++; $display("FAIL full_drain%0d got=%h exp=%h", i, dout, exp); end
            drive(1'b0, 1'b1, 10'h000);
        end
        total++; if (overflow !== STICKY) begin bad++; $display("FAIL ovf_drained got=%b exp=%b", overflow, STICKY); end
    endtask

    task automatic test_underflow();
        apply_reset();
        drive(1'b0, 1'b1, 10'h000);
        total++; if (count !== 4'd0 || dout !== 10'h000)
            begin bad++; $display("FAIL unf_hold got count=%0d dout=%h exp count=0 dout=000", count, dout); end
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL unf_set got=%b exp=1", underflow); end
        sb.push_back(10'h123);
        drive(1'b1, 1'b0, 10'h123);
        total++; if (underflow !== STICKY) begin bad++; $display("FAIL unf_after got=%b exp=%b", underflow, STICKY); end
        total++; if (dout !== sb[$] || count !== 4'd1)
            begin bad++; $display("FAIL unf_push got dout=%h count=%0d exp dout=123 count=1", dout, count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL unf_noovf got=%b exp=0", overflow); end
    endtask

    task automatic test_push_pop_same_cycle();
        logic [9:0] exp;
        apply_reset();
        sb.push_back(10'h040); drive(1'b1, 1'b0, 10'h040);
        sb.push_back(10'h050); drive(1'b1, 1'b0, 10'h050);
        void'(sb.pop_back()); sb.push_back(10'h077);
        drive(1'b1, 1'b1, 10'h077);
        total++; if (count !== 4'd2 || dout !== 10'h077)
            begin bad++; $display("FAIL pp_replace got count=%0d dout=%h exp count=2 dout=077", count, dout); end
        total++; if (overflow !== 1'b0 || underflow !== 1'b0)
            begin bad++; $display("FAIL pp_noerr got=%b%b exp=00", overflow, underflow); end
        for (int i = 0; i < 2; i++) begin
            exp = sb.pop_back();
            total++; if (dout !== exp) begin bad++; $display("FAIL pp_drain%0d got=%h exp=%h", i, dout, exp); end
            drive(1'b0, 1'b1, 10'h000);
        end
        drive(1'b1, 1'b1, 10'h077);
        total++; if (count !== 4'd1 || dout !== 10'h077)
            begin bad++; $display("FAIL pp_empty got count=%0d dout=%h exp count=1 dout=077", count, dout); end
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL pp_empty_nounf got=%b exp=0", underflow); end
    endtask

    task automatic test_reset_mid_op();
        apply_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 10'h100 + 10'(i));
        total++; if (count !== 4'd5) begin bad++; $display("FAIL rmid_pre got=%0d exp=5", count); end
        @(negedge clk);
        push = 1'b1; din = 10'h3C3; reset = 1'b1;
        @(posedge clk); #1;
        push = 1'b0;
        @(negedge clk); reset = 1'b0;
        #1;
        total++; if (count !== 4'd0 || empty !== 1'b1)
            begin bad++; $display("FAIL rmid_lost got count=%0d empty=%b exp count=0 empty=1", count, empty); end
        drive(1'b1, 1'b0, 10'h2AA);
        total++; if (count !== 4'd1 || dout !== 10'h2AA)
            begin bad++; $display("FAIL rmid_push got count=%0d dout=%h exp count=1 dout=2aa", count, dout); end
        sb.delete();
    endtask

    task automatic test_back_to_back();
        int         r;
        logic       do_pop;
        logic [9:0] d;
        logic [9:0] exp;
        logic [3:0] exp_cnt;
        apply_reset();
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 3);
            // Fill-biased first half, drain-biased second half, so both ends are hit.
            do_pop = (i < 40) ? (r == 0) : (r != 0);
            if (do_pop && sb.size() == 0) do_pop = 1'b0;
            if (!do_pop && sb.size() == 8) do_pop = 1'b1;
            if (do_pop) begin
                exp = sb.pop_back();
                total++; if (dout !== exp) begin bad++; $display("FAIL b2b_pop%0d got=%h exp=%h", i, dout, exp); end
                drive(1'b0, 1'b1, 10'h000);
            end else begin
                d = 10'($urandom_range(0, 1023));
                sb.push_back(d);
                drive(1'b1, 1'b0, d);
            end
            exp_cnt = 4'(sb.size());
            total++; if (count !== exp_cnt) begin bad++; $display("FAIL b2b_count%0d got=%0d exp=%0d", i, count, exp_cnt); end
        end
        total++; if (overflow !== 1'b0 || underflow !== 1'b0)
            begin bad++; $display("FAIL b2b_noerr got=%b%b exp=00", overflow, underflow); end
    endtask

    initial begin
        reset = 1'b0; push = 1'b0; pop = 1'b0; din = 10'h000;
        test_reset();
        test_lifo();
        test_full_overflow();
        test_underflow();
        test_push_pop_same_cycle();
        test_reset_mid_op();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
